// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arbiter_if
// Brief   : Bundle for the shared SRAM port. It carries the per-master
//           request/access lines, the grant and read-return lines, and the
//           registered SRAM pins.
//           The slave modport is the arbiter. The master modport is the
//           environment: the decoder masters and the SRAM model.
// Revision: 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        we_n_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic [NUM_REQ-1:0]        rd_valid_o;
    logic [DATA_W-1:0]         rd_data_o;
    logic [ADDR_W-1:0]         SRAM_address_o;
    logic [DATA_W-1:0]         SRAM_write_data_o;
    logic                      SRAM_we_n_o;
    logic [DATA_W-1:0]         SRAM_read_data_i;

    modport master (
        output req_i, we_n_i, addr_i, wdata_i, SRAM_read_data_i,
        input  grant_o, rd_valid_o, rd_data_o,
               SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );

    modport slave (
        input  req_i, we_n_i, addr_i, wdata_i, SRAM_read_data_i,
        output grant_o, rd_valid_o, rd_data_o,
               SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arbiter
// Brief   : Gives the single external SRAM port to one decoder master at a
//           time, for a whole burst.
//           The owner's accesses are registered onto the SRAM pins.
//           Read data returns tagged to the master that issued the read.
//           In-flight reads drain before the port is handed over.
//           Optional feature, macro SRAM_ARB_RR_EN: round-robin arbitration.
//           When the macro is undefined, arbitration is fixed priority and
//           master 0 is highest.
// Revision: 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                Clock_50,
    input  logic                Reset,
    sram_port_arbiter_if.slave  bus
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0]   r_grant;
    logic [ADDR_W-1:0]    r_sram_addr;
    logic [DATA_W-1:0]    r_sram_wdata;
    logic                 r_sram_we_n;
    logic                 r_issue_vld;
    logic [c_IDX_W-1:0]   r_issue_tag;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [c_IDX_W-1:0]   r_pipe_tag [READ_LATENCY];
    logic [NUM_REQ-1:0]   r_rd_valid;
    logic [DATA_W-1:0]    r_rd_data;

    logic [ADDR_W-1:0]    w_addr  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata [NUM_REQ];
    logic                 w_owner_req;
    logic                 w_owner_we_n;
    logic                 w_pipe_busy;
    logic [c_IDX_W-1:0]   w_start;
    logic [c_IDX_W-1:0]   w_winner;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = bus.addr_i[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = bus.wdata_i[g*DATA_W +: DATA_W];
    end

    assign w_owner_req  = bus.req_i[r_owner];
    assign w_owner_we_n = bus.we_n_i[r_owner];
    // The issue stage counts as in flight, so DRAIN also waits for a read issued on the last burst cycle.
    assign w_pipe_busy  = r_issue_vld | (|r_pipe_vld);

    // First requester found when walking upward from 'start' and wrapping.
    // The walk runs from the far end, so the nearest requester is written last and wins.
    function automatic logic [c_IDX_W-1:0] f_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [c_IDX_W-1:0] start);
        logic [c_IDX_W-1:0] pick;
        int                 idx;
        pick = '0;
        for (int d = NUM_REQ - 1; d >= 0; d--) begin
            idx = int'(start) + d;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) pick = c_IDX_W'(idx);
        end
        return pick;
    endfunction

`ifdef SRAM_ARB_RR_EN
    // The rotating pointer is only needed by the round-robin search.
    logic [c_IDX_W-1:0] r_rr_ptr;

    // The search begins one past the last winner, so that winner ranks last.
    always_comb begin
        w_start = (r_rr_ptr == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_rr_ptr + c_IDX_W'(1);
    end

    // Record the last winner on every grant.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_rr_ptr <= c_IDX_W'(NUM_REQ - 1);
        end else if (r_state == S_IDLE && (|bus.req_i)) begin
            r_rr_ptr <= w_winner;
        end
    end
`else
    // Fixed priority: the search always begins at master 0.
    always_comb begin
        w_start = '0;
    end
`endif

    // Choose the winner among the current requesters.
    always_comb begin
        w_winner = f_pick(bus.req_i, w_start);
    end

    // Ownership FSM. It also registers the owner's accesses onto the SRAM pins.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_grant      <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_we_n  <= 1'b1;
            r_issue_vld  <= 1'b0;
            r_issue_tag  <= '0;
        end else begin
            r_issue_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req_i) begin
                        r_owner <= w_winner;
                        r_grant <= c_ONE << w_winner;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_owner_req) begin
                        r_sram_addr  <= w_addr[r_owner];
                        r_sram_wdata <= w_wdata[r_owner];
                        r_sram_we_n  <= w_owner_we_n;
                        if (w_owner_we_n) begin
                            r_issue_vld <= 1'b1;
                            r_issue_tag <= r_owner;
                        end
                    end else begin
                        // Release. The address holds, and the write strobe is parked high.
                        r_grant     <= '0;
                        r_sram_we_n <= 1'b1;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-tag pipeline and tagged return of the SRAM read data.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_pipe_tag[i] <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_pipe_vld[0] <= r_issue_vld;
            r_pipe_tag[0] <= r_issue_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            if (r_pipe_vld[READ_LATENCY-1]) begin
                r_rd_valid <= c_ONE << r_pipe_tag[READ_LATENCY-1];
                r_rd_data  <= bus.SRAM_read_data_i;
            end else begin
                r_rd_valid <= '0;
            end
        end
    end

    assign bus.grant_o           = r_grant;
    assign bus.rd_valid_o        = r_rd_valid;
    assign bus.rd_data_o         = r_rd_data;
    assign bus.SRAM_address_o    = r_sram_addr;
    assign bus.SRAM_write_data_o = r_sram_wdata;
    assign bus.SRAM_we_n_o       = r_sram_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_port_arbiter
// Brief   : Self-checking bench for sram_port_arbiter.
//           A random burst generator pushes the expected SRAM writes and the
//           expected tagged read returns into queues.
//           A negedge monitor pops the queues and compares them against the
//           DUT outputs.
//           A small SRAM model with a read latency serves the port.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;
    localparam int NUM_REQ      = 3;
    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 16;
    localparam int READ_LATENCY = 2;

    logic Clock_50 = 1'b0;
    logic Reset    = 1'b1;
    always #10 Clock_50 = ~Clock_50;

    sram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)
    ) dut (
        .Clock_50(Clock_50),
        .Reset   (Reset),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge Clock_50) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- SRAM model: data is valid READ_LATENCY cycles after the address ----------------
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return 16'h1234 + DATA_W'(a[4:0]) * 16'h0101;
    endfunction

    logic [DATA_W-1:0] mem     [32];
    logic [DATA_W-1:0] rd_pipe [READ_LATENCY];
    always @(posedge Clock_50) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(ADDR_W'(i));
        end else if (!bus.SRAM_we_n_o) begin
            mem[bus.SRAM_address_o[4:0]] <= bus.SRAM_write_data_o;
        end
        rd_pipe[0] <= mem[bus.SRAM_address_o[4:0]];
        for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.SRAM_read_data_i = rd_pipe[READ_LATENCY-1];

    // ---------------- Reference model state ----------------
    typedef struct {
        int                cyc;
        int                m;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_wr[$];
    exp_t exp_rd[$];
    logic [DATA_W-1:0] model_mem [int];
    int last_winner;
    int rel_edge;
    int last_rd_edge;
    logic [NUM_REQ-1:0] active;

    int                plan_len  [NUM_REQ];
    logic              plan_we_n [NUM_REQ][8];
    logic [ADDR_W-1:0] plan_addr [NUM_REQ][8];
    logic [DATA_W-1:0] plan_data [NUM_REQ][8];

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic int model_winner(input logic [NUM_REQ-1:0] reqs);
`ifdef SRAM_ARB_RR_EN
        for (int d = 1; d <= NUM_REQ; d++)
            if (reqs[(last_winner + d) % NUM_REQ]) return (last_winner + d) % NUM_REQ;
`else
        for (int m = 0; m < NUM_REQ; m++)
            if (reqs[m]) return m;
`endif
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- Monitor: pops the scoreboard whenever the DUT presents output ----------------
    exp_t mon_e;
    always @(negedge Clock_50) begin
        if (!Reset) begin
            if (bus.rd_valid_o != '0) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(bus.rd_valid_o), 32'd0);
                end else begin
                    mon_e = exp_rd.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("rd_master", 32'(bus.rd_valid_o), 32'(NUM_REQ'(1) << mon_e.m));
                    chk("rd_data", 32'(bus.rd_data_o), 32'(mon_e.data));
                end
            end
            if (bus.SRAM_we_n_o == 1'b0) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(bus.SRAM_we_n_o), 32'd1);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("wr_addr", 32'(bus.SRAM_address_o), 32'(mon_e.addr));
                    chk("wr_data", 32'(bus.SRAM_write_data_o), 32'(mon_e.data));
                end
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic present(input int m, input int i);
        bus.req_i[m]                     = 1'b1;
        bus.we_n_i[m]                    = plan_we_n[m][i];
        bus.addr_i[m*ADDR_W +: ADDR_W]   = plan_addr[m][i];
        bus.wdata_i[m*DATA_W +: DATA_W]  = plan_data[m][i];
    endtask

    task automatic plan_random(input int m);
        plan_len[m] = $urandom_range(1, 4);
        for (int i = 0; i < plan_len[m]; i++) begin
            plan_we_n[m][i] = 1'($urandom_range(0, 1));
            plan_addr[m][i] = ADDR_W'($urandom_range(0, 15));
            plan_data[m][i] = DATA_W'($urandom);
        end
    endtask

    task automatic start(input int m);
        active[m] = 1'b1;
        present(m, 0);
    endtask

    task automatic wait_grant();
        int waited;
        waited = 0;
        while (bus.grant_o == '0 && waited < 16) begin
            @(posedge Clock_50); #1;
            waited++;
        end
        if (bus.grant_o == '0 || !$onehot(bus.grant_o)) begin
            errors++; checks++;
            $display("FAIL grant_wait: grant_o=%b never became one-hot", bus.grant_o);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "no usable grant");
        end
    endtask

    // Wait for the arbiter to grant one of the active masters, then run that master's burst and release the port.
    task automatic serve();
        int w, k, issue;
        exp_t e;
        w = model_winner(active);
        wait_grant();
        chk("grant", 32'(bus.grant_o), 32'(NUM_REQ'(1) << w));
        chk("handover_gap", 32'(cyc - rel_edge >= 2), 32'd1);
        chk("grant_after_drain", 32'(cyc > last_rd_edge), 32'd1);
        k = 0;
        for (int m = 0; m < NUM_REQ; m++) if (bus.grant_o[m]) k = m;
        last_winner = w;
        for (int i = 0; i < plan_len[k]; i++) begin
            issue  = cyc + 1;
            e.m    = k;
            e.addr = plan_addr[k][i];
            if (!plan_we_n[k][i]) begin
                e.cyc  = issue;
                e.data = plan_data[k][i];
                model_mem[int'(e.addr)] = e.data;
                exp_wr.push_back(e);
            end else begin
                e.cyc  = issue + READ_LATENCY + 1;
                e.data = model_read(e.addr);
                exp_rd.push_back(e);
                last_rd_edge = e.cyc;
            end
            @(posedge Clock_50); #1;
            chk("grant_hold", 32'(bus.grant_o), 32'(NUM_REQ'(1) << k));
            if (i + 1 < plan_len[k]) begin
                present(k, i + 1);
            end else begin
                bus.req_i[k] = 1'b0;
                active[k]    = 1'b0;
            end
        end
        @(posedge Clock_50); #1;
        rel_edge = cyc;
        chk("grant_release", 32'(bus.grant_o), 32'd0);
        chk("we_n_release", 32'(bus.SRAM_we_n_o), 32'd1);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int waited;
        bus.req_i   = '0;
        bus.we_n_i  = '1;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        active       = '0;
        last_winner  = NUM_REQ - 1;
        rel_edge     = -100;
        last_rd_edge = -100;

        repeat (3) @(posedge Clock_50);
        #1;
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data_o), 32'd0);
        chk("rst_addr", 32'(bus.SRAM_address_o), 32'd0);
        chk("rst_wdata", 32'(bus.SRAM_write_data_o), 32'd0);
        chk("rst_we_n", 32'(bus.SRAM_we_n_o), 32'd1);
        Reset = 1'b0;
        @(posedge Clock_50); #1;

        // Single read burst by master 1.
        plan_len[1] = 4;
        for (int i = 0; i < 4; i++) begin
            plan_we_n[1][i] = 1'b1;
            plan_addr[1][i] = ADDR_W'(18'h00010 + i);
            plan_data[1][i] = '0;
        end
        start(1);
        serve();

        // Master 0 writes the top address while master 2 waits, then master 2 reads it back.
        plan_len[0] = 1; plan_we_n[0][0] = 1'b0; plan_addr[0][0] = 18'h3FFFF; plan_data[0][0] = 16'hABCD;
        plan_len[2] = 1; plan_we_n[2][0] = 1'b1; plan_addr[2][0] = 18'h3FFFF; plan_data[2][0] = '0;
        start(0);
        start(2);
        serve();
        serve();

        // All three request together, each with a single access. Master 0 then re-requests.
        for (int m = 0; m < NUM_REQ; m++) begin
            plan_random(m);
            plan_len[m] = 1;
            start(m);
        end
        serve();
        plan_random(0);
        start(0);
        serve();
        serve();
        serve();

        // Random traffic.
        for (int r = 0; r < 40; r++) begin
            for (int m = 0; m < NUM_REQ; m++) begin
                if (!active[m] && $urandom_range(0, 2) == 0) begin
                    plan_random(m);
                    start(m);
                end
            end
            if (active == '0) begin
                waited = $urandom_range(0, NUM_REQ - 1);
                plan_random(waited);
                start(waited);
            end
            serve();
        end
        while (active != '0) serve();

        // Reset while master 1 has three reads in flight.
        plan_len[1] = 6;
        for (int i = 0; i < 6; i++) begin
            plan_we_n[1][i] = 1'b1;
            plan_addr[1][i] = ADDR_W'($urandom_range(0, 15));
            plan_data[1][i] = '0;
        end
        start(1);
        wait_grant();
        chk("t1_grant", 32'(bus.grant_o), 32'(3'b010));
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock_50); #1;
            present(1, i + 1);
        end
        Reset = 1'b1;
        #1;
        chk("t1_grant_rst", 32'(bus.grant_o), 32'd0);
        chk("t1_rd_valid_rst", 32'(bus.rd_valid_o), 32'd0);
        chk("t1_rd_data_rst", 32'(bus.rd_data_o), 32'd0);
        chk("t1_addr_rst", 32'(bus.SRAM_address_o), 32'd0);
        chk("t1_wdata_rst", 32'(bus.SRAM_write_data_o), 32'd0);
        chk("t1_we_n_rst", 32'(bus.SRAM_we_n_o), 32'd1);
        bus.req_i = '0;
        active    = '0;
        last_winner  = NUM_REQ - 1;
        rel_edge     = -100;
        last_rd_edge = -100;
        model_mem.delete();
        repeat (2) @(posedge Clock_50);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock_50); #1;
            chk("t1_no_rd_after_rst", 32'(bus.rd_valid_o), 32'd0);
        end

        // The port works normally again after the reset.
        plan_random(2);
        start(2);
        serve();

        waited = 0;
        while ((exp_rd.size() != 0 || exp_wr.size() != 0) && waited < 20) begin
            @(posedge Clock_50); #1;
            waited++;
        end
        chk("scoreboard_empty", 32'(exp_rd.size() + exp_wr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
